adc_serial_master_fsync_gen: RTL and testbench

//  Parametrised multi-channel ADC serial source in frame-sync master mode: emits sck, fsync and dout for NCH channels
//  of DW-bit samples, in daisy-chain (one dout) or parallel-lane (one dout per channel) mode.

---
 rtl/adc_serial_master_fsync_gen.sv | 158 +++++++++++++++
 tb/tb_adc_serial_master_fsync_gen.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/adc_serial_master_fsync_gen.sv
// Frame-sync master ADC serial source: sck/fsync/dout for NCH channels of DW-bit samples, daisy-chain or parallel lanes.
// Outputs are registered; a frame always runs to completion once started, and en only decides whether another follows.
module adc_serial_master_fsync_gen #(
    parameter int DW        = 24,
    parameter int NCH       = 1,
    parameter int SCK_DIV   = 2,
    parameter int FRAME_SCK = 32,
    parameter int DOUT_MODE = 0,
    localparam int NL       = (DOUT_MODE != 0) ? NCH : 1
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              en,
    input  logic [NCH*DW-1:0] ch_data,
    input  logic              data_valid,
    output logic              sck,
    output logic              fsync,
    output logic [NL-1:0]     dout,
    output logic              sample_tick,
    output logic              stale,
    output logic              busy,
    output logic [15:0]       frame_cnt
);
    localparam int HCW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int BCW = (FRAME_SCK > 1) ? $clog2(FRAME_SCK) : 1;
    localparam int IW  = (NCH * DW > 1) ? $clog2(NCH * DW) : 1;

    generate
        if (NCH < 1 || NCH > 8 || DW < 1 || SCK_DIV < 1 ||
            (DOUT_MODE != 0 && DOUT_MODE != 1) ||
            (DOUT_MODE == 0 && FRAME_SCK < NCH * DW) ||
            (DOUT_MODE == 1 && FRAME_SCK < DW)) begin : g_bad_param
            $error("adc_serial_master_fsync_gen: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

    state_t            state, state_nx;
    logic [HCW-1:0]    hc, hc_nx;
    logic [BCW-1:0]    bc, bc_nx;
    logic [NCH*DW-1:0] lat, lat_nx;
    logic [NCH*DW-1:0] src;
    logic [NL-1:0]     dout_nx;
    logic [15:0]       cnt_nx;
    logic              sck_nx, fsync_nx, tick_nx, stale_nx;
    logic              half_end, start;

    // Serial bit n of the frame on every lane; bits past the payload are 0.
    function automatic logic [NL-1:0] bits_at(input logic [NCH*DW-1:0] w, input int n);
        logic [NL-1:0] r;
        logic [IW-1:0] idx;
        r   = '0;
        idx = '0;
        if (DOUT_MODE == 0) begin
            if (n < NCH * DW) begin
                idx  = IW'((n / DW) * DW + DW - 1 - (n % DW));
                r[0] = w[idx];
            end
        end else begin
            for (int k = 0; k < NL; k++) begin
                if (n < DW) begin
                    idx  = IW'(k * DW + DW - 1 - n);
                    r[k] = w[idx];
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        state_nx = state;
        hc_nx    = hc;
        bc_nx    = bc;
        lat_nx   = lat;
        sck_nx   = sck;
        fsync_nx = fsync;
        dout_nx  = dout;
        tick_nx  = 1'b0;
        stale_nx = stale;
        cnt_nx   = frame_cnt;
        start    = 1'b0;
        half_end = (hc == HCW'(SCK_DIV - 1));
        src      = data_valid ? ch_data : lat;

        case (state)
            S_IDLE: begin
                if (en) start = 1'b1;
            end
            default: begin
                state_nx = en ? S_RUN : S_STOP;
                hc_nx    = half_end ? '0 : hc + 1'b1;
                if (half_end) begin
                    sck_nx = ~sck;
                    if (sck) begin
                        // Falling edge: advance the bit; the receiver samples on the next rise.
                        fsync_nx = 1'b0;
                        bc_nx    = bc + 1'b1;
                        dout_nx  = bits_at(lat, int'(bc) + 1);
                        if (bc == BCW'(FRAME_SCK - 1)) begin
                            if (en) begin
                                start = 1'b1;
                            end else begin
                                state_nx = S_IDLE;
                                sck_nx   = 1'b0;
                                dout_nx  = '0;
                                bc_nx    = '0;
                                hc_nx    = '0;
                            end
                        end
                    end
                end
            end
        endcase

        if (start) begin
            state_nx = S_RUN;
            hc_nx    = '0;
            bc_nx    = '0;
            sck_nx   = 1'b0;
            fsync_nx = 1'b1;
            tick_nx  = 1'b1;
            cnt_nx   = frame_cnt + 16'd1;
            lat_nx   = src;
            stale_nx = stale | ~data_valid;
            dout_nx  = bits_at(src, 0);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state       <= S_IDLE;
            hc          <= '0;
            bc          <= '0;
            lat         <= '0;
            sck         <= 1'b0;
            fsync       <= 1'b0;
            dout        <= '0;
            sample_tick <= 1'b0;
            stale       <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_nx;
            hc          <= hc_nx;
            bc          <= bc_nx;
            lat         <= lat_nx;
            sck         <= sck_nx;
            fsync       <= fsync_nx;
            dout        <= dout_nx;
            sample_tick <= tick_nx;
            stale       <= stale_nx;
            frame_cnt   <= cnt_nx;
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_adc_serial_master_fsync_gen.sv
// Directed bench for adc_serial_master_fsync_gen: default, 2-channel daisy-chain and 4-lane parallel instances.
module tb_adc_serial_master_fsync_gen;
    logic aclk = 1'b0;
    logic areset, dv;
    logic en0, en1, en2;
    logic [23:0] d0;
    logic [47:0] d1;
    logic [95:0] d2;
    logic sck0, fs0, tick0, stale0, busy0;
    logic sck1, fs1, tick1, stale1, busy1;
    logic sck2, fs2, tick2, stale2, busy2;
    logic [0:0] dout0, dout1;
    logic [3:0] dout2;
    logic [15:0] cnt0, cnt1, cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 aclk = ~aclk;

    adc_serial_master_fsync_gen u0 (
        .aclk(aclk), .areset(areset), .en(en0), .ch_data(d0), .data_valid(dv),
        .sck(sck0), .fsync(fs0), .dout(dout0), .sample_tick(tick0), .stale(stale0),
        .busy(busy0), .frame_cnt(cnt0)
    );

    adc_serial_master_fsync_gen #(.NCH(2), .SCK_DIV(1), .FRAME_SCK(64), .DOUT_MODE(0)) u1 (
        .aclk(aclk), .areset(areset), .en(en1), .ch_data(d1), .data_valid(dv),
        .sck(sck1), .fsync(fs1), .dout(dout1), .sample_tick(tick1), .stale(stale1),
        .busy(busy1), .frame_cnt(cnt1)
    );

    adc_serial_master_fsync_gen #(.NCH(4), .SCK_DIV(1), .FRAME_SCK(32), .DOUT_MODE(1)) u2 (
        .aclk(aclk), .areset(areset), .en(en2), .ch_data(d2), .data_valid(dv),
        .sck(sck2), .fsync(fs2), .dout(dout2), .sample_tick(tick2), .stale(stale2),
        .busy(busy2), .frame_cnt(cnt2)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] bits0;
        logic [63:0] bits1;
        logic [31:0] lane [4];
        logic [23:0] ch2 [4];
        logic        prev;
        int          nfs, ntk, nrise, i;

        areset = 1'b1; dv = 1'b1;
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        d0 = '0; d1 = '0; d2 = '0;
        tick(); tick();
        chk("rst_sck", {63'd0, sck0}, 64'd0);
        chk("rst_fsync", {63'd0, fs0}, 64'd0);
        chk("rst_dout", {63'd0, dout0}, 64'd0);
        chk("rst_busy_tick_stale", {61'd0, busy0, tick0, stale0}, 64'd0);
        chk("rst_cnt", {48'd0, cnt0}, 64'd0);

        // Default instance, one full frame of 24'h800001
        areset = 1'b0; d0 = 24'h800001; en0 = 1'b1;
        tick();
        chk("f1_start", {58'd0, fs0, tick0, busy0, dout0, sck0, 1'b0}, {58'd0, 6'b111100});
        chk("f1_cnt", {48'd0, cnt0}, 64'd1);
        bits0 = '0; nfs = 0; ntk = 0; nrise = 0; prev = sck0;
        for (int c = 0; c < 128; c++) begin
            if (sck0 && !prev) begin
                bits0 = {bits0[30:0], dout0[0]};
                nrise++;
            end
            if (fs0) nfs++;
            if (tick0) ntk++;
            prev = sck0;
            tick();
        end
        chk("f1_bits", {32'd0, bits0}, {32'd0, 32'h8000_0100});
        chk("f1_rises", 64'(nrise), 64'd32);
        chk("f1_fsync_len", 64'(nfs), 64'd4);
        chk("f1_tick_count", 64'(ntk), 64'd1);
        chk("f2_start_no_gap", {62'd0, tick0, fs0}, 64'd3);
        chk("f2_cnt", {48'd0, cnt0}, 64'd2);

        // Drop en at bit 5 of frame 2; the frame must still run its full length
        i = 0;
        repeat (20) begin tick(); i++; end
        en0 = 1'b0;
        while (busy0 && i < 400) begin tick(); i++; end
        chk("stop_len", 64'(i), 64'd128);
        chk("stop_idle_outs", {61'd0, sck0, fs0, dout0}, 64'd0);
        chk("stop_cnt", {48'd0, cnt0}, 64'd2);
        repeat (5) tick();
        chk("idle_quiet", {60'd0, sck0, fs0, dout0, busy0}, 64'd0);

        // Reset while sck is high and dout is 1 (bit 10)
        d0 = 24'hFFFFFF; en0 = 1'b1;
        tick();
        chk("f3_cnt", {48'd0, cnt0}, 64'd3);
        repeat (42) tick();
        chk("pre_rst_active", {62'd0, sck0, dout0}, 64'd3);
        areset = 1'b1;
        tick();
        chk("midrst_outs", {59'd0, sck0, fs0, dout0, busy0, tick0}, 64'd0);
        chk("midrst_cnt", {48'd0, cnt0}, 64'd0);
        areset = 1'b0;
        tick();
        chk("post_rst_start", {61'd0, fs0, tick0, dout0}, 64'd7);
        chk("post_rst_cnt", {48'd0, cnt0}, 64'd1);

        // Frame counter wrap
        repeat (10) tick();
        force u0.frame_cnt = 16'hFFFF;
        tick();
        release u0.frame_cnt;
        chk("wrap_forced", {48'd0, cnt0}, 64'h0000_0000_0000_FFFF);
        i = 0;
        while (!tick0 && i < 300) begin tick(); i++; end
        chk("wrap_zero", {48'd0, cnt0}, 64'd0);
        en0 = 1'b0;
        i = 0;
        while (busy0 && i < 300) begin tick(); i++; end
        chk("u0_drained", {63'd0, busy0}, 64'd0);

        // Two channels daisy-chained: ch0 = FFFFFF first, then ch1 = 000001, then padding
        d1 = {24'h000001, 24'hFFFFFF}; en1 = 1'b1;
        tick();
        bits1 = '0; nrise = 0; prev = sck1;
        for (int c = 0; c < 128; c++) begin
            if (sck1 && !prev) begin
                bits1 = {bits1[62:0], dout1[0]};
                nrise++;
            end
            prev = sck1;
            tick();
        end
        chk("chain_bits", bits1, {24'hFFFFFF, 24'h000001, 16'h0000});
        chk("chain_rises", 64'(nrise), 64'd64);
        en1 = 1'b0;
        i = 0;
        while (busy1 && i < 300) begin tick(); i++; end
        chk("u1_drained", {62'd0, busy1, sck1}, 64'd0);

        // Four parallel lanes; frame 2 has data_valid low and must replay frame 1
        ch2[0] = 24'hA5A5A5; ch2[1] = 24'h123456; ch2[2] = 24'hFFFFFF; ch2[3] = 24'h000001;
        d2 = {ch2[3], ch2[2], ch2[1], ch2[0]}; dv = 1'b1; en2 = 1'b1;
        tick();
        chk("lanes_f1_stale", {63'd0, stale2}, 64'd0);
        dv = 1'b0; d2 = '0;
        for (int f = 1; f <= 2; f++) begin
            for (int k = 0; k < 4; k++) lane[k] = '0;
            prev = sck2;
            for (int c = 0; c < 64; c++) begin
                if (sck2 && !prev)
                    for (int k = 0; k < 4; k++) lane[k] = {lane[k][30:0], dout2[k]};
                prev = sck2;
                tick();
            end
            for (int k = 0; k < 4; k++)
                chk($sformatf("lanes_f%0d_k%0d", f, k), {32'd0, lane[k]}, {32'd0, ch2[k], 8'h00});
            chk($sformatf("lanes_f%0d_end_stale", f), {63'd0, stale2}, 64'd1);
        end
        en2 = 1'b0;
        i = 0;
        while (busy2 && i < 300) begin tick(); i++; end
        chk("stale_sticky", {62'd0, stale2, busy2}, 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
